// File: rtl/pll_pkg.sv
// pll_pkg: shared PLL types and constants for the PFD/charge-pump block
package pll_pkg;
   localparam int VCTRL_W = 16;
   typedef logic [VCTRL_W-1:0] vctrl_t;
   localparam real VCTRL_FULL_SCALE_V = 3.0;
endpackage

// File: rtl/pfd_charge_pump_if.sv
// pfd_charge_pump_if: clock inputs, PFD pulses and control-voltage code bundle
interface pfd_charge_pump_if #(
   parameter int VCTRL_W = pll_pkg::VCTRL_W
);
   logic               d;
   logic               ref_in;
   logic               fb_in;
   logic               up;
   logic               down;
   logic [VCTRL_W-1:0] vctrl;
   logic               sat_hi;
   logic               sat_lo;
   modport master (output d, ref_in, fb_in, input up, down, vctrl, sat_hi, sat_lo);
   modport slave  (input d, ref_in, fb_in, output up, down, vctrl, sat_hi, sat_lo);
endinterface

// File: rtl/pfd_core.sv
// pfd_core: input synchronizers, rising-edge detect and tri-state PFD with anti-backlash clear
module pfd_core #(
   parameter int SYNC_STAGES = 2,
   parameter int ABL_CYCLES  = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   input  logic ref_in,
   input  logic fb_in,
   output logic up,
   output logic down
);
   localparam int CW = (ABL_CYCLES > 1) ? $clog2(ABL_CYCLES) : 1;
   logic [SYNC_STAGES-1:0] ref_sync;
   logic [SYNC_STAGES-1:0] fb_sync;
   logic                   ref_prev;
   logic                   fb_prev;
   logic [CW-1:0]          abl_cnt;
   logic                   ref_rise;
   logic                   fb_rise;
   logic                   clear;
   assign ref_rise = ref_sync[SYNC_STAGES-1] & ~ref_prev;
   assign fb_rise  = fb_sync[SYNC_STAGES-1] & ~fb_prev;
   assign clear    = up & down & (abl_cnt == CW'(ABL_CYCLES - 1));
   // shift both clocks through their synchronizer chains and remember last output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_sync <= '0;
         fb_sync  <= '0;
         ref_prev <= 1'b0;
         fb_prev  <= 1'b0;
      end else begin
         ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
         fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_in};
         ref_prev <= ref_sync[SYNC_STAGES-1];
         fb_prev  <= fb_sync[SYNC_STAGES-1];
      end
   end
   // clear wins over new edges, so an edge landing in the clear cycle is lost (dead zone)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up      <= 1'b0;
         down    <= 1'b0;
         abl_cnt <= '0;
      end else if (clear) begin
         up      <= 1'b0;
         down    <= 1'b0;
         abl_cnt <= '0;
      end else begin
         if (ref_rise) up <= d;
         if (fb_rise) down <= d;
         abl_cnt <= (up & down) ? abl_cnt + CW'(1) : '0;
      end
   end
endmodule

// File: rtl/pfd_charge_pump.sv
// pfd_charge_pump: PFD driving a saturating charge-pump integrator (loop-filter voltage code)
module pfd_charge_pump #(
   parameter int VCTRL_W     = pll_pkg::VCTRL_W,
   parameter int VCTRL_INIT  = 32768,
   parameter int I_STEP      = 64,
   parameter int SYNC_STAGES = 2,
   parameter int ABL_CYCLES  = 1
) (
   input logic               clk,
   input logic               rst_n,
   pfd_charge_pump_if.slave  bus
);
   localparam logic [VCTRL_W-1:0] MAX_CODE = {VCTRL_W{1'b1}};
   localparam logic [VCTRL_W:0]   STEP     = (VCTRL_W + 1)'(I_STEP);
   logic               up;
   logic               down;
   logic [VCTRL_W-1:0] vctrl;
   logic [VCTRL_W-1:0] vctrl_nxt;
   logic [VCTRL_W:0]   sum;
   logic [VCTRL_W:0]   dif;
   pfd_core #(
      .SYNC_STAGES (SYNC_STAGES),
      .ABL_CYCLES  (ABL_CYCLES)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .d      (bus.d),
      .ref_in (bus.ref_in),
      .fb_in  (bus.fb_in),
      .up     (up),
      .down   (down)
   );
   // the extra top bit of sum/dif flags overflow past full scale or borrow below zero
   assign sum = {1'b0, vctrl} + STEP;
   assign dif = {1'b0, vctrl} - STEP;
   // next capacitor code: source, sink, or hold when both/neither pump is on
   always_comb begin
      vctrl_nxt = (up & ~down) ? (sum[VCTRL_W] ? MAX_CODE : sum[VCTRL_W-1:0]) :
                  (down & ~up) ? (dif[VCTRL_W] ? '0 : dif[VCTRL_W-1:0]) : vctrl;
   end
   // integrate charge onto the loop-filter capacitor
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vctrl <= VCTRL_W'(VCTRL_INIT);
      else vctrl <= vctrl_nxt;
   end
   assign bus.up     = up;
   assign bus.down   = down;
   assign bus.vctrl  = vctrl;
   assign bus.sat_hi = (vctrl == MAX_CODE);
   assign bus.sat_lo = (vctrl == '0);
endmodule

// File: tb/tb_pfd_charge_pump.sv
// tb_pfd_charge_pump: vector table, corner sequences and random run against a behavioural PLL model
module tb_pfd_charge_pump;
   import pll_pkg::*;
   localparam int S    = 2;
   localparam int ABL  = 1;
   localparam int STEP = 64;
   localparam int INIT = 32768;
   localparam int MAXV = 65535;
   typedef struct {
      int delay;
      bit d;
      int exp_v;
   } vec_t;
   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   int     checks = 0;
   int     failures = 0;
   bit     mon = 1'b0;
   bit     r_hist[0:S];
   bit     f_hist[0:S];
   bit     m_up, m_dn, rr, fr;
   int     m_both;
   int     m_v;
   vec_t   vecs[6];
   pfd_charge_pump_if bus ();
   pfd_charge_pump dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // behavioural model: delay line of samples, phase-error pump with clamp arithmetic
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int i = 0; i <= S; i++) begin
            r_hist[i] = 1'b0;
            f_hist[i] = 1'b0;
         end
         m_up = 1'b0;
         m_dn = 1'b0;
         m_both = 0;
         m_v = INIT;
      end else begin
         rr = r_hist[S-1] && !r_hist[S];
         fr = f_hist[S-1] && !f_hist[S];
         if (m_up && !m_dn) m_v = (m_v + STEP > MAXV) ? MAXV : m_v + STEP;
         else if (m_dn && !m_up) m_v = (m_v - STEP < 0) ? 0 : m_v - STEP;
         if (m_up && m_dn && m_both >= ABL) begin
            m_up = 1'b0;
            m_dn = 1'b0;
         end else begin
            if (rr) m_up = bus.d;
            if (fr) m_dn = bus.d;
         end
         m_both = (m_up && m_dn) ? m_both + 1 : 0;
         for (int i = S; i > 0; i--) begin
            r_hist[i] = r_hist[i-1];
            f_hist[i] = f_hist[i-1];
         end
         r_hist[0] = bus.ref_in;
         f_hist[0] = bus.fb_in;
      end
   end
   // every cycle, compare all outputs with the model on the falling edge
   initial forever begin
      @(negedge clk);
      if (mon) begin
         chk("mon_up", {31'd0, bus.up}, {31'd0, m_up});
         chk("mon_down", {31'd0, bus.down}, {31'd0, m_dn});
         chk("mon_vctrl", {16'd0, bus.vctrl}, m_v);
         chk("mon_sat_hi", {31'd0, bus.sat_hi}, {31'd0, m_v == MAXV});
         chk("mon_sat_lo", {31'd0, bus.sat_lo}, {31'd0, m_v == 0});
      end
   end
   task automatic do_reset();
      @(negedge clk);
      bus.ref_in = 1'b0;
      bus.fb_in = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         bus.ref_in = ~bus.ref_in;
         bus.fb_in = ~bus.fb_in;
      end
      chk("rst_up", {31'd0, bus.up}, 32'd0);
      chk("rst_down", {31'd0, bus.down}, 32'd0);
      chk("rst_vctrl", {16'd0, bus.vctrl}, INIT);
      bus.ref_in = 1'b0;
      bus.fb_in = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask
   initial begin
      bus.d = 1'b1;
      bus.ref_in = 1'b0;
      bus.fb_in = 1'b0;
      vecs[0] = '{delay: 10, d: 1'b1, exp_v: 33408};
      vecs[1] = '{delay: -5, d: 1'b1, exp_v: 32448};
      vecs[2] = '{delay: 0, d: 1'b1, exp_v: 32768};
      vecs[3] = '{delay: 1, d: 1'b1, exp_v: 32832};
      vecs[4] = '{delay: -1, d: 1'b1, exp_v: 32704};
      vecs[5] = '{delay: 10, d: 1'b0, exp_v: 32768};
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      mon = 1'b1;
      do_reset();
      repeat (5) @(negedge clk);
      chk("idle_vctrl", {16'd0, bus.vctrl}, INIT);
      // edge-to-up latency: input change before edge k shows on up after edge k+2
      @(negedge clk);
      bus.ref_in = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 chk("lat_up_early", {31'd0, bus.up}, 32'd0);
      @(posedge clk);
      #1 chk("lat_up", {31'd0, bus.up}, 32'd1);
      @(posedge clk);
      #1 chk("lat_vctrl", {16'd0, bus.vctrl}, INIT + STEP);
      foreach (vecs[v]) begin
         do_reset();
         for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.d = vecs[v].d;
            bus.ref_in = (c >= 10 && c < 25);
            bus.fb_in = (c >= 10 + vecs[v].delay && c < 25 + vecs[v].delay);
         end
         @(negedge clk);
         chk($sformatf("vec%0d_vctrl", v), {16'd0, bus.vctrl}, vecs[v].exp_v);
         chk($sformatf("vec%0d_up", v), {31'd0, bus.up}, 32'd0);
         chk($sformatf("vec%0d_down", v), {31'd0, bus.down}, 32'd0);
      end
      bus.d = 1'b1;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         bus.ref_in = c[3];
      end
      chk("climb_vctrl", {16'd0, bus.vctrl}, MAXV);
      chk("climb_sat_hi", {31'd0, bus.sat_hi}, 32'd1);
      chk("climb_up", {31'd0, bus.up}, 32'd1);
      do_reset();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         bus.fb_in = c[3];
      end
      chk("fall_vctrl", {16'd0, bus.vctrl}, 32'd0);
      chk("fall_sat_lo", {31'd0, bus.sat_lo}, 32'd1);
      chk("fall_down", {31'd0, bus.down}, 32'd1);
      // reset in the middle of pumping restores the initial code without a clock edge
      do_reset();
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         bus.ref_in = c[2];
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("abort_vctrl", {16'd0, bus.vctrl}, INIT);
      chk("abort_up", {31'd0, bus.up}, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if ($urandom_range(3) == 0) bus.ref_in = ~bus.ref_in;
         if ($urandom_range(3) == 0) bus.fb_in = ~bus.fb_in;
         bus.d = ($urandom_range(15) != 0);
      end
      @(negedge clk);
      mon = 1'b0;
      $display("final vctrl %0d = %f V", bus.vctrl, real'(bus.vctrl) * VCTRL_FULL_SCALE_V / real'(MAXV));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pfd_charge_pump.md
Name: pfd_charge_pump

Overview:
- Synchronous, oversampled model of a PLL phase-frequency detector (PFD) feeding a charge pump and loop-filter capacitor.
- Rising edges of the reference and feedback clocks, sampled on a fast system clock, drive a tri-state PFD (UP / DOWN / NEUTRAL).
- The PFD outputs integrate into a saturating control-voltage code that represents the loop-filter capacitor voltage (0..3.0 V full scale).
- The block sits between the clock sources (refclk and the divided VCO output) and the VCO control input.

Parameters:
- VCTRL_W, 16: width of the control-voltage code; 0 = 0 V, 2^VCTRL_W-1 = 3.0 V.
- VCTRL_INIT, 32768: reset value of vctrl (1.5 V initial capacitor voltage).
- I_STEP, 64: code change per clk cycle while pumping (charge-pump current × Tclk / C).
- SYNC_STAGES, 2: synchronizer depth applied to ref_in and fb_in; minimum 2.
- ABL_CYCLES, 1: cycles both up and down stay high before the PFD clears (anti-backlash pulse); minimum 1.

Ports:
- clk  input  1  system sampling clock; must be much faster than ref_in and fb_in.
- rst_n  input  1  asynchronous active-low reset.
- d  input  1  PFD flip-flop data input; tie to 1 for normal operation.
- ref_in  input  1  reference clock, asynchronous to clk.
- fb_in  input  1  feedback clock, asynchronous to clk.
- up  output  1  PFD up pulse (charge source on).
- down  output  1  PFD down pulse (charge sink on).
- vctrl  output  VCTRL_W  control-voltage code (capacitor voltage).
- sat_hi  output  1  high while vctrl = 2^VCTRL_W-1.
- sat_lo  output  1  high while vctrl = 0.

Behaviour:
- Reset (async assert, sync release): all synchronizer and edge-detect flops 0; up=0, down=0, anti-backlash counter 0; vctrl=VCTRL_INIT; sat flags reflect vctrl.
- ref_in and fb_in each pass through a SYNC_STAGES-flop chain. A rising edge is detected when the chain output is 1 and its previous-cycle value was 0.
- Edge to up/down latency: a transition sampled at edge k shows up on up/down after edge k+SYNC_STAGES (3 clk edges from input change with defaults).
- PFD register update, in priority order each clk:
  - Clear: if up and down have both been 1 for ABL_CYCLES consecutive cycles, both go to 0. An edge detected in the clear cycle is dropped (dead zone).
  - Otherwise, on a ref rise, up <= d; on a fb rise, down <= d. A register holds when there is no edge.
  - Simultaneous ref and fb rises set both flops; they then clear after ABL_CYCLES.
  - d=0: a detected edge loads 0 into the corresponding flop.
- Anti-backlash counter: increments while up&down, resets to 0 otherwise and on clear.
- Charge pump, registered, using the current up/down values:
  - up & ~down: vctrl += I_STEP, saturating at 2^VCTRL_W-1.
  - down & ~up: vctrl -= I_STEP, saturating at 0.
  - Both high or both low: hold.
  - Compute in VCTRL_W+1 bits, then clamp.
- vctrl therefore changes one edge after up/down change.
- sat_hi and sat_lo are combinational decodes of vctrl.
- Reset mid-pump aborts immediately; vctrl returns to VCTRL_INIT.

Decomposition:
- Shared package pll_pkg: VCTRL_W default; a vctrl_t typedef; VCTRL_FULL_SCALE_V = 3.0, used only by the bench to convert codes to volts.
- One natural sub-module, pfd_core: synchronizers, edge detect, up/down flops and anti-backlash clear.
- The charge-pump integrator stays in the top block.

Test Plan:
- Reset: hold rst_n=0, toggle both clocks → up=0, down=0, vctrl=32768. Release → no change until an edge is detected.
- Ref leads fb by 10 clk cycles, d=1 → up high 10 cycles, then both high 1 cycle, then both 0. vctrl = 32768+640 = 33408.
- Fb leads ref by 5 cycles → down high 5 cycles, then the clear. vctrl = 32768-320 = 32448.
- Aligned edges (ref_in and fb_in change on the same clk) → up and down rise together, clear after 1 cycle, vctrl unchanged.
- Ref toggles only (fb_in stuck 0) → up stays high. vctrl climbs by 64 per cycle to 65535 in 512 cycles, then holds; sat_hi=1. Mirror case with fb only → vctrl reaches 0, sat_lo=1.
- d=0 with ref edges → up never asserts, vctrl stays 32768. Asserting rst_n=0 mid-pump → vctrl returns to 32768 asynchronously.
